instruction_buffer: RTL and testbench

INSTRUCTION_BUFFER -- requirements
Module: instruction_buffer

---
 rtl/instruction_buffer.sv | 144 ++++++++++++++
 tb/tb_instruction_buffer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_buffer.sv
// Byte-to-word instruction assembler with a small FIFO and an issue stage.
// Define RUN_EXPAND_EN to hold RUN words for RUN_CYCLES cycles. Otherwise every opcode issues for one cycle.
module instruction_buffer #(
    parameter int FIFO_DEPTH = 4,
    parameter int RUN_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic        flush,
    output logic [15:0] instruction,
    output logic        busy,
    output logic [3:0]  fifo_count
);
    localparam int         PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [3:0] DEPTH_CNT = 4'(FIFO_DEPTH);

    logic [15:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [3:0]       count_reg;
    logic             phase_reg;
    logic [7:0]       high_byte_reg;
    logic [15:0]      instr_reg;
    logic             accept;
    logic             push;
    logic             pop;
    logic [15:0]      head_word;

    // Ready depends only on registered count, so a pop on this edge cannot raise it.
    assign byte_ready = (count_reg < DEPTH_CNT);
    assign accept     = byte_valid & byte_ready & ~flush;
    assign push       = accept & phase_reg;
    assign head_word  = fifo_mem[rd_ptr_reg];

    assign instruction = instr_reg;
    assign fifo_count  = count_reg;

    // Storage is deliberately left unreset; only pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {high_byte_reg, byte_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= 4'd0;
            phase_reg     <= 1'b0;
            high_byte_reg <= 8'h00;
        end else if (flush) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= 4'd0;
            phase_reg     <= 1'b0;
            high_byte_reg <= 8'h00;
        end else begin
            if (accept) begin
                phase_reg <= ~phase_reg;
                if (!phase_reg) begin
                    high_byte_reg <= byte_in;
                end
            end
            // Power-of-two depth: pointer overflow is the modulo wrap.
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + {3'b000, push} - {3'b000, pop};
        end
    end

`ifdef RUN_EXPAND_EN
    typedef enum logic {
        IDLE,
        REPEAT
    } state_t;

    localparam logic [1:0] OP_RUN   = 2'b01;
    localparam logic [2:0] RUN_LAST = 3'(RUN_CYCLES - 1);

    state_t     state_reg;
    logic [2:0] counter_reg;
    logic       issue_free;

    // The final REPEAT cycle behaves like IDLE so the next word follows with no NOP gap.
    assign issue_free = (state_reg == IDLE) || (counter_reg == 3'd0);
    assign pop        = issue_free && (count_reg != 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            counter_reg <= 3'd0;
            instr_reg   <= 16'h0000;
        end else if (flush) begin
            state_reg   <= IDLE;
            counter_reg <= 3'd0;
            instr_reg   <= 16'h0000;
        end else if (issue_free) begin
            if (pop) begin
                instr_reg <= head_word;
                if (head_word[15:14] == OP_RUN) begin
                    state_reg   <= REPEAT;
                    counter_reg <= RUN_LAST;
                end else begin
                    state_reg   <= IDLE;
                    counter_reg <= 3'd0;
                end
            end else begin
                state_reg   <= IDLE;
                counter_reg <= 3'd0;
                instr_reg   <= 16'h0000;
            end
        end else begin
            counter_reg <= counter_reg - 3'd1;
        end
    end

    assign busy = phase_reg | (count_reg != 4'd0) | (state_reg == REPEAT);
`else
    assign pop = (count_reg != 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_reg <= 16'h0000;
        end else if (flush) begin
            instr_reg <= 16'h0000;
        end else if (pop) begin
            instr_reg <= head_word;
        end else begin
            instr_reg <= 16'h0000;
        end
    end

    assign busy = phase_reg | (count_reg != 4'd0);
`endif

endmodule

// File: tb/tb_instruction_buffer.sv
// Directed bench for instruction_buffer; expectations follow RUN_EXPAND_EN when it is defined.
module tb_instruction_buffer;
`ifdef RUN_EXPAND_EN
    localparam int RUN_LEN = 8;
`else
    localparam int RUN_LEN = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        flush;
    logic [15:0] instruction;
    logic        busy;
    logic [3:0]  fifo_count;

    int vectors;
    int miscompares;

    logic [7:0]  tx   [16];
    logic [15:0] ilog [32];
    logic        rlog [32];
    logic        blog [32];
    logic [3:0]  clog [32];

    instruction_buffer #(
        .FIFO_DEPTH(4),
        .RUN_CYCLES(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .flush      (flush),
        .instruction(instruction),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offer tx[0..n-1] in order, holding each byte until accepted; sample k reflects edge k.
    task automatic drive_bytes(input int n, input int cycles);
        int   idx;
        logic offered;
        idx     = 0;
        offered = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (offered && k > 0) begin
                if (rlog[k-1]) idx++;
            end
            ilog[k] = instruction;
            rlog[k] = byte_ready;
            blog[k] = busy;
            clog[k] = fifo_count;
            if (idx < n) begin
                byte_valid = 1'b1;
                byte_in    = tx[idx];
                offered    = 1'b1;
            end else begin
                byte_valid = 1'b0;
                offered    = 1'b0;
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        flush      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        #2;
        repeat (2) @(negedge clk);
        vectors++;
        if (instruction !== 16'h0000 || fifo_count !== 4'd0 || byte_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: instr=%h count=%0d ready=%b busy=%b, expected 0000/0/1/0",
                     instruction, fifo_count, byte_ready, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (instruction !== 16'h0000 || byte_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release: instr=%h ready=%b, expected 0000/1", instruction, byte_ready);
        end
        $display("test_reset: instr=%h count=%0d ready=%b busy=%b", instruction, fifo_count, byte_ready, busy);
    endtask

    task automatic test_basic_issue();
        tx[0] = 8'h9A;
        tx[1] = 8'h55;
        drive_bytes(2, 6);
        vectors++;
        if (blog[1] !== 1'b1 || clog[1] !== 4'd0) begin
            miscompares++;
            $display("FAIL basic_partial: busy=%b count=%0d, expected busy=1 count=0", blog[1], clog[1]);
        end
        vectors++;
        if (clog[2] !== 4'd1) begin
            miscompares++;
            $display("FAIL basic_count: count=%0d, expected 1", clog[2]);
        end
        for (int k = 1; k < 6; k++) begin
            logic [15:0] e;
            e = (k == 3) ? 16'h9A55 : 16'h0000;
            vectors++;
            if (ilog[k] !== e) begin
                miscompares++;
                $display("FAIL basic_instr[%0d]: got %h expected %h", k, ilog[k], e);
            end
        end
        vectors++;
        if (blog[4] !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_idle_busy: busy=%b expected 0", blog[4]);
        end
        $display("test_basic_issue: bytes 9a 55 -> instruction %h one cycle after accept", ilog[3]);
    endtask

    task automatic test_run();
        logic exp_busy;
        exp_busy = (RUN_LEN > 1) ? 1'b1 : 1'b0;
        tx[0] = 8'h40;
        tx[1] = 8'h00;
        drive_bytes(2, 3 + RUN_LEN + 3);
        for (int k = 1; k < 3 + RUN_LEN + 3; k++) begin
            logic [15:0] e;
            e = (k >= 3 && k < 3 + RUN_LEN) ? 16'h4000 : 16'h0000;
            vectors++;
            if (ilog[k] !== e) begin
                miscompares++;
                $display("FAIL run_instr[%0d]: got %h expected %h", k, ilog[k], e);
            end
        end
        for (int k = 3; k < 3 + RUN_LEN; k++) begin
            vectors++;
            if (blog[k] !== exp_busy) begin
                miscompares++;
                $display("FAIL run_busy[%0d]: got %b expected %b", k, blog[k], exp_busy);
            end
        end
        vectors++;
        if (blog[3 + RUN_LEN] !== 1'b0) begin
            miscompares++;
            $display("FAIL run_end_busy: got %b expected 0", blog[3 + RUN_LEN]);
        end
        $display("test_run: RUN 4000 held for %0d cycle(s)", RUN_LEN);
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_i [14];
`ifdef RUN_EXPAND_EN
        exp_i = '{16'h0000, 16'h0000, 16'h0000, 16'h4000, 16'h4000, 16'h4000, 16'h4000,
                  16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'hC600, 16'h0000, 16'h0000};
`else
        exp_i = '{16'h0000, 16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'hC600, 16'h0000,
                  16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
`endif
        tx[0] = 8'h40;
        tx[1] = 8'h00;
        tx[2] = 8'hC6;
        tx[3] = 8'h00;
        drive_bytes(4, 14);
        for (int k = 1; k < 14; k++) begin
            vectors++;
            if (ilog[k] !== exp_i[k]) begin
                miscompares++;
                $display("FAIL b2b_instr[%0d]: got %h expected %h", k, ilog[k], exp_i[k]);
            end
        end
        $display("test_back_to_back: RUN then STORE, store seen %h", ilog[(RUN_LEN > 1) ? 11 : 5]);
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_i [18];
        logic [3:0]  exp_c [18];
        logic        exp_r [18];
`ifdef RUN_EXPAND_EN
        exp_i = '{16'h0000, 16'h0000, 16'h0000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000,
                  16'h4000, 16'h4000, 16'h8001, 16'h8002, 16'h8003, 16'h8004, 16'h8005, 16'h0000, 16'h0000};
        exp_c = '{4'd0, 4'd0, 4'd1, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3,
                  4'd3, 4'd4, 4'd3, 4'd2, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0};
        exp_r = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`else
        exp_i = '{16'h0000, 16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h8001, 16'h0000, 16'h8002, 16'h0000,
                  16'h8003, 16'h0000, 16'h8004, 16'h0000, 16'h8005, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        exp_c = '{4'd0, 4'd0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd1,
                  4'd0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        exp_r = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
        tx[0] = 8'h40;
        tx[1] = 8'h00;
        for (int w = 0; w < 5; w++) begin
            tx[2 + 2*w] = 8'h80;
            tx[3 + 2*w] = 8'(w + 1);
        end
        drive_bytes(12, 18);
        for (int k = 1; k < 18; k++) begin
            vectors++;
            if (ilog[k] !== exp_i[k] || clog[k] !== exp_c[k] || rlog[k] !== exp_r[k]) begin
                miscompares++;
                $display("FAIL bp_cycle[%0d]: instr=%h count=%0d ready=%b, expected %h/%0d/%b",
                         k, ilog[k], clog[k], rlog[k], exp_i[k], exp_c[k], exp_r[k]);
            end
        end
        $display("test_backpressure: 5 words behind RUN, peak count %0d", clog[10]);
    endtask

    task automatic test_flush();
        logic [3:0] exp_q;
        exp_q = (RUN_LEN > 1) ? 4'd2 : 4'd1;
        tx[0] = 8'h40;
        tx[1] = 8'h00;
        tx[2] = 8'h81;
        tx[3] = 8'h11;
        tx[4] = 8'h82;
        tx[5] = 8'h22;
        tx[6] = 8'hA1;
        drive_bytes(7, 8);
        vectors++;
        if (clog[6] !== exp_q || blog[7] !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_pre: count=%0d busy=%b, expected %0d/1", clog[6], blog[7], exp_q);
        end
        flush      = 1'b1;
        byte_valid = 1'b1;
        byte_in    = 8'h55;
        @(negedge clk);
        flush      = 1'b0;
        byte_valid = 1'b0;
        vectors++;
        if (instruction !== 16'h0000 || fifo_count !== 4'd0 || busy !== 1'b0 || byte_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_clear: instr=%h count=%0d busy=%b ready=%b, expected 0000/0/0/1",
                     instruction, fifo_count, busy, byte_ready);
        end
        tx[0] = 8'h81;
        tx[1] = 8'h07;
        drive_bytes(2, 5);
        vectors++;
        if (ilog[1] !== 16'h0000 || ilog[2] !== 16'h0000) begin
            miscompares++;
            $display("FAIL flush_quiet: got %h %h expected 0000 0000", ilog[1], ilog[2]);
        end
        vectors++;
        if (ilog[3] !== 16'h8107 || ilog[4] !== 16'h0000) begin
            miscompares++;
            $display("FAIL flush_resume: got %h %h expected 8107 0000", ilog[3], ilog[4]);
        end
        $display("test_flush: after flush bytes 81 07 -> %h", ilog[3]);
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] e5;
        e5 = (RUN_LEN > 1) ? 16'h4000 : 16'h0000;
        tx[0] = 8'h40;
        tx[1] = 8'h00;
        tx[2] = 8'hC1;
        drive_bytes(3, 6);
        vectors++;
        if (ilog[3] !== 16'h4000 || ilog[5] !== e5) begin
            miscompares++;
            $display("FAIL rmr_pre: got %h %h expected 4000 %h", ilog[3], ilog[5], e5);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (instruction !== 16'h0000 || fifo_count !== 4'd0 || busy !== 1'b0 || byte_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rmr_async: instr=%h count=%0d busy=%b ready=%b, expected 0000/0/0/1",
                     instruction, fifo_count, busy, byte_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            vectors++;
            if (instruction !== 16'h0000 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL rmr_no_resume[%0d]: instr=%h busy=%b, expected 0000/0", k, instruction, busy);
            end
        end
        tx[0] = 8'h83;
        tx[1] = 8'h04;
        drive_bytes(2, 5);
        vectors++;
        if (ilog[3] !== 16'h8304) begin
            miscompares++;
            $display("FAIL rmr_phase: got %h expected 8304", ilog[3]);
        end
        $display("test_reset_mid_run: after reset bytes 83 04 -> %h", ilog[3]);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic_issue();
        test_run();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
